// File: rtl/fifo_sync_pkt_mem.sv
// Simple dual-port storage for fifo_sync_pkt: one synchronous write port and
// one asynchronous read port. The async read serves both the fall-through
// and the registered read modes of the FIFO.
module fifo_sync_pkt_mem #(
   parameter int WIDTH      = 9,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port: store the word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_pkt.sv
// Single-clock packet FIFO. Words are written with an end-of-packet marker and
// become visible to the reader only once the packet's last word is accepted.
// Pending words can be discarded with push_drop; a packet that overflows is
// discarded automatically.
//
// Handshake: push and pop are strobes qualified by the registered flags of the
// same cycle. A push is taken when push & ~full & ~push_drop, a pop when
// pop & ~empty. Both are evaluated against the pre-edge state; a refused push
// produces a one-cycle overflow pulse, a refused pop is silently ignored.
module fifo_sync_pkt #(
   parameter int DATA_WIDTH        = 8,
   parameter int ADDR_WIDTH        = 4,
   parameter int FALL              = 1,
   parameter int LEAD_ALMOST_FULL  = 2,
   parameter int LEAD_ALMOST_EMPTY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_push,
   input  logic                  push_last,
   input  logic                  push_drop,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_pop,
   output logic                  pop_last,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  full_almost,
   output logic                  empty,
   output logic                  empty_almost,
   output logic                  overflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int MW    = DATA_WIDTH + 1;

   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   // Thresholds clamped so that oversized leads saturate instead of wrapping.
   localparam logic [PW-1:0] AF_TH =
      PW'((LEAD_ALMOST_FULL >= DEPTH) ? 0 : DEPTH - LEAD_ALMOST_FULL);
   localparam logic [PW-1:0] AE_TH =
      PW'((LEAD_ALMOST_EMPTY >= DEPTH) ? DEPTH : LEAD_ALMOST_EMPTY);

   logic [PW-1:0] waddr, caddr, raddr;
   logic [PW-1:0] waddr_nxt, caddr_nxt, raddr_nxt;
   logic [PW-1:0] count_nxt, level_nxt;
   logic          pkt_err, pkt_err_nxt;
   logic          push_acc, push_ref, pop_acc;
   logic [MW-1:0] rd_word;

   assign push_acc = push & ~full & ~push_drop;
   assign push_ref = push & full;
   assign pop_acc  = pop & ~empty;

   fifo_sync_pkt_mem #(
      .WIDTH      (MW),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_acc),
      .waddr (waddr[ADDR_WIDTH-1:0]),
      .wdata ({push_last, data_push}),
      .raddr (raddr[ADDR_WIDTH-1:0]),
      .rdata (rd_word)
   );

   // Next-state of the write/commit/read pointers and the packet error flag.
   always_comb begin
      waddr_nxt   = waddr;
      caddr_nxt   = caddr;
      raddr_nxt   = raddr;
      pkt_err_nxt = pkt_err;
      if (push_drop) begin
         waddr_nxt   = caddr;
         pkt_err_nxt = 1'b0;
      end else if (push_acc) begin
         if (push_last && pkt_err) begin
            // Packet already lost a word: throw the remainder away.
            waddr_nxt   = caddr;
            pkt_err_nxt = 1'b0;
         end else if (push_last) begin
            waddr_nxt = waddr + PW'(1);
            caddr_nxt = waddr + PW'(1);
         end else begin
            waddr_nxt = waddr + PW'(1);
         end
      end else if (push_ref) begin
         if (push_last) begin
            // The refused word ends the packet, so nothing would ever drop
            // it later; discard the pending words now.
            waddr_nxt   = caddr;
            pkt_err_nxt = 1'b0;
         end else begin
            pkt_err_nxt = 1'b1;
         end
      end
      if (pop_acc) begin
         raddr_nxt = raddr + PW'(1);
      end
      count_nxt = caddr_nxt - raddr_nxt;
      level_nxt = waddr_nxt - raddr_nxt;
   end

   // Pointer, occupancy and flag registers, all updated on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         waddr        <= '0;
         caddr        <= '0;
         raddr        <= '0;
         pkt_err      <= 1'b0;
         count        <= '0;
         level        <= '0;
         full         <= 1'b0;
         full_almost  <= (AF_TH == '0);
         empty        <= 1'b1;
         empty_almost <= 1'b1;
         overflow     <= 1'b0;
      end else begin
         waddr        <= waddr_nxt;
         caddr        <= caddr_nxt;
         raddr        <= raddr_nxt;
         pkt_err      <= pkt_err_nxt;
         count        <= count_nxt;
         level        <= level_nxt;
         full         <= (level_nxt == DEPTH_P);
         full_almost  <= (level_nxt >= AF_TH);
         empty        <= (count_nxt == '0);
         empty_almost <= (count_nxt <= AE_TH);
         overflow     <= push_ref;
      end
   end

   generate
      if (FALL != 0) begin : g_fall
         // Fall-through: present the head word whenever something is readable.
         always_comb begin
            data_pop = '0;
            pop_last = 1'b0;
            if (!empty) begin
               data_pop = rd_word[DATA_WIDTH-1:0];
               pop_last = rd_word[DATA_WIDTH];
            end
         end
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] data_q;
         logic                  last_q;
         // Registered read: capture the head word on each accepted pop.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_q <= '0;
               last_q <= 1'b0;
            end else if (pop_acc) begin
               data_q <= rd_word[DATA_WIDTH-1:0];
               last_q <= rd_word[DATA_WIDTH];
            end
         end
         assign data_pop = data_q;
         assign pop_last = last_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_pkt.sv
// Bench for fifo_sync_pkt: a fall-through and a registered-read instance are
// driven with identical stimulus and compared against a queue-based model.
module tb_fifo_sync_pkt;

   localparam int DW = 6;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic [DW-1:0] data_push = '0;
   logic          push_last = 1'b0;
   logic          push_drop = 1'b0;
   logic          pop = 1'b0;

   logic [DW-1:0] dp_1, dp_0;
   logic          pl_1, pl_0;
   logic [AW:0]   cnt_1, cnt_0, lvl_1, lvl_0;
   logic          full_1, full_0, fa_1, fa_0, emp_1, emp_0, ea_1, ea_0;
   logic          ovf_1, ovf_0;

   int n_checks = 0;
   int n_err    = 0;

   // Model: committed packets, pending words, error flag, registered read word.
   logic [DW:0] q_c[$];
   logic [DW:0] q_p[$];
   logic        m_err = 1'b0;
   logic        m_ovf = 1'b0;
   logic [DW:0] m_d0  = '0;

   always #5 clk = ~clk;

   fifo_sync_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FALL(1),
                   .LEAD_ALMOST_FULL(2), .LEAD_ALMOST_EMPTY(2)) u_f1 (
      .clk(clk), .rst(rst), .push(push), .data_push(data_push),
      .push_last(push_last), .push_drop(push_drop), .pop(pop),
      .data_pop(dp_1), .pop_last(pl_1), .count(cnt_1), .level(lvl_1),
      .full(full_1), .full_almost(fa_1), .empty(emp_1),
      .empty_almost(ea_1), .overflow(ovf_1));

   fifo_sync_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FALL(0),
                   .LEAD_ALMOST_FULL(2), .LEAD_ALMOST_EMPTY(2)) u_f0 (
      .clk(clk), .rst(rst), .push(push), .data_push(data_push),
      .push_last(push_last), .push_drop(push_drop), .pop(pop),
      .data_pop(dp_0), .pop_last(pl_0), .count(cnt_0), .level(lvl_0),
      .full(full_0), .full_almost(fa_0), .empty(emp_0),
      .empty_almost(ea_0), .overflow(ovf_0));

   logic [43:0] dut_vec;
   assign dut_vec = {cnt_1, lvl_1, full_1, fa_1, emp_1, ea_1, ovf_1, dp_1, pl_1,
                     cnt_0, lvl_0, full_0, fa_0, emp_0, ea_0, ovf_0, dp_0, pl_0};

   function automatic logic [43:0] exp_vec();
      int          c  = q_c.size();
      int          lv = q_c.size() + q_p.size();
      logic [DW:0] hd = (c > 0) ? q_c[0] : '0;
      logic [14:0] st;
      st = {5'(c), 5'(lv), (lv == 16), (lv >= 14), (c == 0), (c <= 2), m_ovf};
      return {st, hd[DW-1:0], hd[DW], st, m_d0[DW-1:0], m_d0[DW]};
   endfunction

   // One clock: drive at negedge, update the model at posedge, settle #1.
   task automatic cyc(input logic r, input logic p, input logic [DW-1:0] d,
                      input logic l, input logic dr, input logic po);
      int  c, lv;
      bit  pacc, pref, popacc;
      @(negedge clk);
      rst = r; push = p; data_push = d; push_last = l; push_drop = dr; pop = po;
      @(posedge clk);
      if (r) begin
         q_c.delete(); q_p.delete(); m_err = 0; m_ovf = 0; m_d0 = '0;
      end else begin
         c      = q_c.size();
         lv     = c + q_p.size();
         pref   = p && (lv == 16);
         pacc   = p && (lv != 16) && !dr;
         popacc = po && (c != 0);
         m_ovf  = pref;
         if (popacc) m_d0 = q_c.pop_front();
         if (dr) begin
            q_p.delete(); m_err = 0;
         end else if (pacc) begin
            q_p.push_back({l, d});
            if (l && m_err) begin
               q_p.delete(); m_err = 0;
            end else if (l) begin
               foreach (q_p[i]) q_c.push_back(q_p[i]);
               q_p.delete();
            end
         end else if (pref) begin
            if (l) begin
               q_p.delete(); m_err = 0;
            end else begin
               m_err = 1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         $display("FAIL reset_vec: got %h expected %h", dut_vec, exp_vec()); n_err++;
      end
      n_checks++;
      if (cnt_1 !== 0 || lvl_0 !== 0 || emp_0 !== 1 || ea_1 !== 1 || fa_0 !== 0 ||
          full_1 !== 0 || ovf_0 !== 0 || dp_0 !== 0 || pl_1 !== 0) begin
         $display("FAIL reset_values: got %h", dut_vec); n_err++;
      end
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_commit();
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 1, DW'(i), 0, 0, 0);
         n_checks++;
         if (cnt_1 !== 0 || emp_1 !== 1) begin
            $display("FAIL commit_hidden: count %0d empty %0d expected 0 1", cnt_1, emp_1);
            n_err++;
         end
      end
      cyc(0, 1, 5, 1, 0, 0);
      n_checks++;
      if (cnt_1 !== 5 || lvl_1 !== 5 || dp_1 !== 1 || pl_1 !== 0) begin
         $display("FAIL commit_visible: count %0d level %0d data %0d last %0d expected 5 5 1 0",
                  cnt_1, lvl_1, dp_1, pl_1);
         n_err++;
      end
      for (int i = 1; i <= 5; i++) begin
         n_checks++;
         if (dp_1 !== DW'(i) || pl_1 !== (i == 5)) begin
            $display("FAIL fall_data: got %0d/%0d expected %0d/%0d", dp_1, pl_1, i, (i == 5));
            n_err++;
         end
         cyc(0, 0, 0, 0, 0, 1);
         n_checks++;
         if (dp_0 !== DW'(i) || pl_0 !== (i == 5)) begin
            $display("FAIL reg_data: got %0d/%0d expected %0d/%0d", dp_0, pl_0, i, (i == 5));
            n_err++;
         end
      end
      n_checks++;
      if (emp_1 !== 1 || dut_vec !== exp_vec()) begin
         $display("FAIL commit_drained: got %h expected %h", dut_vec, exp_vec()); n_err++;
      end
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (dp_0 !== 5 || pl_0 !== 1 || ovf_0 !== 0) begin
         $display("FAIL reg_hold: data %0d last %0d expected 5 1", dp_0, pl_0); n_err++;
      end
   endtask

   task automatic test_drop();
      int peak = 0;
      for (int i = 0; i < 3; i++) cyc(0, 1, DW'(20 + i), 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (lvl_1 !== 0 || dut_vec !== exp_vec()) begin
         $display("FAIL drop_level: level %0d expected 0", lvl_1); n_err++;
      end
      cyc(0, 1, 7, 0, 0, 0);
      cyc(0, 1, 8, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (int'(cnt_1) > peak) peak = int'(cnt_1);
         cyc(0, 0, 0, 0, 0, 1);
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            $display("FAIL drop_read: got %h expected %h", dut_vec, exp_vec()); n_err++;
         end
      end
      n_checks++;
      if (peak !== 2 || dp_0 !== 8 || pl_0 !== 1) begin
         $display("FAIL drop_peak: peak %0d last_data %0d expected 2 8", peak, dp_0); n_err++;
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 16; i++) cyc(0, 1, DW'(i), 0, 0, 0);
      n_checks++;
      if (full_1 !== 1 || lvl_0 !== 16 || ovf_1 !== 0) begin
         $display("FAIL full_set: full %0d level %0d expected 1 16", full_1, lvl_0); n_err++;
      end
      cyc(0, 1, 17, 1, 0, 0);
      n_checks++;
      if (ovf_1 !== 1 || ovf_0 !== 1 || lvl_1 !== 0 || emp_1 !== 1 || full_0 !== 0) begin
         $display("FAIL overflow_drop: ovf %0d level %0d empty %0d expected 1 0 1",
                  ovf_1, lvl_1, emp_1);
         n_err++;
      end
      cyc(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (ovf_1 !== 0 || dut_vec !== exp_vec()) begin
         $display("FAIL overflow_pulse: ovf %0d expected 0", ovf_1); n_err++;
      end
   endtask

   task automatic test_almost_wrap();
      for (int i = 1; i <= 14; i++) cyc(0, 1, DW'(i + 30), (i == 14), 0, 0);
      n_checks++;
      if (fa_1 !== 1 || lvl_1 !== 14 || cnt_0 !== 14) begin
         $display("FAIL almost_full: fa %0d level %0d expected 1 14", fa_1, lvl_1); n_err++;
      end
      for (int i = 1; i <= 12; i++) begin
         cyc(0, 0, 0, 0, 0, 1);
         n_checks++;
         if (ea_1 !== (i == 12) || dut_vec !== exp_vec()) begin
            $display("FAIL almost_empty: ea %0d count %0d expected %0d", ea_1, cnt_1, (i == 12));
            n_err++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, DW'($urandom_range(0, 63)), 1, 0, 1);
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            $display("FAIL wrap_stream: got %h expected %h", dut_vec, exp_vec()); n_err++;
         end
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
      n_checks++;
      if (emp_0 !== 1 || dut_vec !== exp_vec()) begin
         $display("FAIL wrap_drain: got %h expected %h", dut_vec, exp_vec()); n_err++;
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 1, 11, 0, 0, 0);
      cyc(0, 1, 12, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, DW'(40 + i), 0, 0, 0);
      cyc(1, 1, 43, 0, 0, 0);
      n_checks++;
      if (cnt_1 !== 0 || lvl_1 !== 0 || emp_0 !== 1 || ea_0 !== 1 || dp_1 !== 0 ||
          dp_0 !== 0 || pl_0 !== 0 || dut_vec !== exp_vec()) begin
         $display("FAIL reset_mid: got %h expected %h", dut_vec, exp_vec()); n_err++;
      end
      cyc(0, 1, 50, 0, 0, 0);
      cyc(0, 1, 51, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0, 0, 1);
         n_checks++;
         if (dp_0 !== DW'(50 + i) || pl_0 !== (i == 1) || dut_vec !== exp_vec()) begin
            $display("FAIL reset_readback: got %0d expected %0d", dp_0, 50 + i); n_err++;
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 60),
             DW'($urandom_range(0, 63)),
             ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 4),
             ($urandom_range(0, 99) < 45));
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec()); n_err++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_drop();
      test_overflow();
      test_almost_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_sync_pkt.md
# fifo_sync_pkt

Single-clock packet FIFO, the parametrised successor to `fifo_sync`. Writers stream words tagged with an end-of-packet marker, and a packet only becomes visible to the reader once its last word is accepted (commit). A partially written packet can be discarded (rollback), and a packet that overflows is discarded automatically. It sits between Opal Kelly pipe/host endpoints and core datapaths, where only whole frames may be consumed.

## Interface
- DATA_WIDTH, 8: payload bits per word.
- ADDR_WIDTH, 4: depth = 2^ADDR_WIDTH words.
- FALL, 1: 1 = first-word fall-through; 0 = registered read.
- LEAD_ALMOST_FULL, 2: full_almost asserts when level >= depth − LEAD_ALMOST_FULL.
- LEAD_ALMOST_EMPTY, 2: empty_almost asserts when count <= LEAD_ALMOST_EMPTY.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write strobe.
- data_push  in  DATA_WIDTH  write data.
- push_last  in  1  qualifies push: this word ends the packet.
- push_drop  in  1  discard all uncommitted words.
- pop  in  1  read strobe.
- data_pop  out  DATA_WIDTH  read data.
- pop_last  out  1  data_pop is the last word of its packet.
- count  out  ADDR_WIDTH+1  committed words readable.
- level  out  ADDR_WIDTH+1  committed plus pending words (storage used).
- full, full_almost, empty, empty_almost  out  1  status flags.
- overflow  out  1  one-cycle pulse when a push is refused.

## Operation
- Storage holds DATA_WIDTH+1 bits per word: data and the last flag.
- Three pointers, each ADDR_WIDTH+1 bits, wrap modulo 2^(ADDR_WIDTH+1):
  - waddr: write head.
  - caddr: commit point.
  - raddr: read head.
- count = caddr − raddr. level = waddr − raddr.
- full = (level == depth). empty = (count == 0). All flags are registered and consistent with count and level after the same edge.
- Push accepted (push & ~full & ~push_drop):
  - Write the word at waddr, then increment waddr.
  - If push_last is also set, caddr ← waddr+1, which commits the packet including this word.
- Push refused (push & full):
  - overflow pulses.
  - The sticky pkt_err is set.
- pkt_err set and an accepted push_last arrives: the packet is dropped (waddr ← caddr) instead of committed, and pkt_err clears.
- push_drop: waddr ← caddr and pkt_err clears. A push in the same cycle is discarded. With no pending words this is a no-op.
- Pop is accepted when pop & ~empty, and raddr increments. Pop while empty is ignored and produces no flag.
- FALL=1: data_pop and pop_last show mem[raddr] whenever ~empty (combinational read). Pop consumes the word.
- FALL=0: an accepted pop registers mem[raddr] into data_pop/pop_last. Both outputs hold their value until the next accepted pop.
- Simultaneous push and pop: both are evaluated against the pre-edge state. There is no write-to-read bypass, and a word committed at edge N is first poppable in the cycle after N.
- A packet larger than depth always overflows and is dropped. This is intended.

## Timing
- Reset values:
  - Pointers and pkt_err = 0.
  - count = level = 0.
  - empty = empty_almost = 1.
  - full = full_almost = overflow = 0 (full_almost = 1 only if LEAD_ALMOST_FULL >= depth).
  - data_pop = 0, pop_last = 0.
- Reset mid-packet discards all contents, committed and pending.
- Commit latency: push_last accepted at edge N → count, empty and empty_almost updated after edge N. In FALL=1, data_pop is valid in that same cycle.
- FALL=0 read latency: pop at edge N → data_pop valid after edge N.
- full is visible after the edge on which the last slot fills. A push in the next cycle is refused.
- overflow is high for exactly the cycle following the refused push edge.

## Structure
- No shared package is needed. Depth, pointer width and threshold comparisons are localparams inside the module.
- One sub-module, fifo_sync_pkt_mem: simple dual-port RAM, (2^ADDR_WIDTH) × (DATA_WIDTH+1).
  - Synchronous write.
  - Asynchronous read, so it serves both FALL modes.
- Pointer, commit and flag logic live in the top level.

## Test plan
Defaults: DATA_WIDTH=6, ADDR_WIDTH=4, FALL=1, leads = 2.
1. Push 5 words 1..5 with push_last on word 5:
   - count stays 0 and empty=1 through words 1–4.
   - After word 5: count=5, level=5, data_pop=1, pop_last=0.
   - Pop 5 times → data 1,2,3,4,5 with pop_last=1 only on 5, then empty=1.
2. Push 3 words, assert push_drop, then push packet 7,8 with last:
   - level returns to 0 after the drop.
   - Only 7,8 are read out; count peaks at 2.
3. Push 17 words, last on word 17:
   - full=1 after word 16 and overflow pulses once.
   - The packet is dropped: level=0, empty=1.
4. Commit a 14-word packet:
   - full_almost=1 (level 14 >= 14).
   - Pop 12 → empty_almost=1 at count=2.
   - Then pop and push simultaneously for 10 cycles across the pointer wrap; the data order is preserved.
5. Rerun scenario 1 with FALL=0:
   - data_pop updates one edge after each pop and holds otherwise.
   - Pop while empty leaves data_pop at 5.
6. Assert rst mid-packet (after 3 of 6 pushes, with one packet committed):
   - All outputs return to reset values on the next edge.
   - A subsequent 2-word packet reads back correctly.
